multdiv_unit: RTL



---
 rtl/multdiv_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply/divide for the execute stage.
// Multiply uses radix-4 Booth (16 steps). Divide uses non-restoring division on
// magnitudes (32 steps), with the sign fixed up at the end.
// Optional macro MULTDIV_REMAINDER_EN adds the data_remainder output.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef MULTDIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0] state;
  logic [4:0] cnt;
  logic       err_sticky;

  // Booth state: {mhi, mlo, mq} is the 66-bit partial-product register.
  logic [WIDTH:0]   mhi;
  logic [WIDTH-1:0] mlo;
  logic             mq;
  logic [WIDTH-1:0] mcand;

  // Divider state: signed partial remainder, quotient/dividend shift reg, divisor magnitude.
  logic [WIDTH:0]   drem;
  logic [WIDTH-1:0] dquo;
  logic [WIDTH-1:0] dvsr;
  logic             dneg;
  logic             dzero;
  logic             dovf;
`ifdef MULTDIV_REMAINDER_EN
  logic             dasign;
`endif

  logic start_mul, start_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH+1:0] mc_ext, booth_add, booth_sum;
  logic [WIDTH:0]   mhi_n;
  logic [WIDTH-1:0] mlo_n;
  logic             mq_n;
  logic [2*WIDTH-1:0] prod;
  logic             mul_ovf;

  logic [WIDTH:0]   dshift, drem_n;
  logic [WIDTH-1:0] dquo_n, q_fix;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH:0]   rrest;
  logic [WIDTH-1:0] r_fix;
`endif

  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign busy           = (state != IDLE);
  assign data_resultRDY = (state == DONE);

  // One radix-4 Booth step: add the selected multiple, then shift right by two.
  always_comb begin
    mc_ext = {{2{mcand[WIDTH-1]}}, mcand};
    booth_add = '0;
    case ({mlo[1:0], mq})
      3'b001, 3'b010: booth_add = mc_ext;
      3'b011:         booth_add = mc_ext << 1;
      3'b100:         booth_add = -(mc_ext << 1);
      3'b101, 3'b110: booth_add = -mc_ext;
      default:        booth_add = '0;
    endcase
    booth_sum = {mhi[WIDTH], mhi} + booth_add;
    mhi_n     = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:2]};
    mlo_n     = {booth_sum[1:0], mlo[WIDTH-1:2]};
    mq_n      = mlo[1];
    prod      = {mhi_n[WIDTH-1:0], mlo_n};
    // Overflow unless the upper 33 bits are a pure sign extension.
    mul_ovf   = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
  end

  // One non-restoring divide step plus the final sign and remainder fix-up.
  always_comb begin
    dshift = {drem[WIDTH-1:0], dquo[WIDTH-1]};
    if (drem[WIDTH]) drem_n = dshift + {1'b0, dvsr};
    else             drem_n = dshift - {1'b0, dvsr};
    dquo_n = {dquo[WIDTH-2:0], ~drem_n[WIDTH]};
    q_fix  = dneg ? -dquo_n : dquo_n;
`ifdef MULTDIV_REMAINDER_EN
    rrest  = drem_n[WIDTH] ? (drem_n + {1'b0, dvsr}) : drem_n;
    r_fix  = dasign ? -rrest[WIDTH-1:0] : rrest[WIDTH-1:0];
`endif
  end

  // Control FSM, datapath registers and held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      err_sticky     <= 1'b0;
      mhi            <= '0;
      mlo            <= '0;
      mq             <= 1'b0;
      mcand          <= '0;
      drem           <= '0;
      dquo           <= '0;
      dvsr           <= '0;
      dneg           <= 1'b0;
      dzero          <= 1'b0;
      dovf           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      dasign         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      if (ctrl_MULT && ctrl_DIV) err_sticky <= 1'b1;
      if (start_mul) begin
        state <= MULT;
        cnt   <= '0;
        mhi   <= '0;
        mlo   <= data_operandB;
        mq    <= 1'b0;
        mcand <= data_operandA;
      end else if (start_div) begin
        state <= DIV;
        cnt   <= '0;
        drem  <= '0;
        dquo  <= a_mag;
        dvsr  <= b_mag;
        dneg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dzero <= (data_operandB == '0);
        dovf  <= (data_operandA == MIN_NEG) && (&data_operandB);
`ifdef MULTDIV_REMAINDER_EN
        dasign <= data_operandA[WIDTH-1];
`endif
      end else begin
        case (state)
          MULT: begin
            mhi <= mhi_n;
            mlo <= mlo_n;
            mq  <= mq_n;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              state          <= DONE;
              data_result    <= prod[WIDTH-1:0];
              data_exception <= mul_ovf;
            end
          end
          DIV: begin
            drem <= drem_n;
            dquo <= dquo_n;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state          <= DONE;
              data_result    <= dzero ? '0 : q_fix;
              data_exception <= dzero | dovf;
`ifdef MULTDIV_REMAINDER_EN
              data_remainder <= dzero ? '0 : r_fix;
`endif
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
